// File: rtl/mux_scan.sv
// mux_scan: registered N-channel, W-bit multiplexer with a built-in channel
// scanner. Manual mode follows an external select. Scan mode steps through
// the channels with a programmable dwell time. The output word is tagged
// with the index of the channel it came from.
module mux_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4,
  parameter int CNT_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      wrap
);

  // One bit wider than sel, so that the range check against CHANNELS works
  // even when CHANNELS == 2**SEL_W.
  localparam logic [SEL_W:0]   NUM_CH   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_PTR = SEL_W'(CHANNELS-1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL-1);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] ch_q;
  logic             valid_q;
  logic             wrap_q, wrap_d;

  // Unpack the flat input bus into one word per channel.
  logic [WIDTH-1:0] chan_w [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_w[gi] = data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Select the word addressed by the pointer. The pointer never leaves
  // 0..CHANNELS-1, so the zero default is never used in operation.
  always_comb begin
    out_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ptr_q == SEL_W'(k)) out_d = chan_w[k];
    end
  end

  // Pointer / dwell counter next state for manual and scan modes.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (!mode) begin
      // Manual: out-of-range selects leave the pointer untouched.
      cnt_d = '0;
      if ({1'b0, sel} < NUM_CH) ptr_d = sel;
    end else if (!hold) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        // Wrap at CHANNELS-1, never at 2**SEL_W-1.
        if (ptr_q == LAST_PTR) begin
          ptr_d  = '0;
          wrap_d = 1'b1;
        end else begin
          ptr_d = ptr_q + SEL_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ch_q    <= ptr_q;
      valid_q <= 1'b1;
      wrap_q  <= wrap_d;
    end
  end

  assign out   = out_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: scoreboard bench for mux_scan. Three instances cover the
// default configuration, a 4-bit/5-channel manual case and a 5-channel
// single-cycle-dwell scan. Stimulus pushes expected responses tagged with
// the edge number they belong to; a monitor on the falling edge checks them.
module tb_mux_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic hold = 1'b0;
  logic [2:0] sel = 3'd0;

  logic [7:0]  data0 = 8'b0010_0000;
  logic [19:0] data1 = {4'd7, 4'd6, 4'd5, 4'd4, 4'd3};
  logic [4:0]  data2 = 5'b01101;

  logic [0:0] out0, out2;
  logic [3:0] out1;
  logic [2:0] ch0, ch1, ch2;
  logic       valid0, valid1, valid2;
  logic       wrap0, wrap1, wrap2;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         dut;
    int         at;
    string      name;
    logic [3:0] out;
    logic [2:0] ch;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t q[$];

  mux_scan #(.WIDTH(1), .CHANNELS(8), .SEL_W(3), .DWELL(4), .CNT_W(2)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(data0), .mode(mode), .sel(sel),
    .hold(hold), .out(out0), .ch(ch0), .valid(valid0), .wrap(wrap0)
  );

  mux_scan #(.WIDTH(4), .CHANNELS(5), .SEL_W(3), .DWELL(4), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(data1), .mode(mode), .sel(sel),
    .hold(hold), .out(out1), .ch(ch1), .valid(valid1), .wrap(wrap1)
  );

  mux_scan #(.WIDTH(1), .CHANNELS(5), .SEL_W(3), .DWELL(1), .CNT_W(1)) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(data2), .mode(mode), .sel(sel),
    .hold(hold), .out(out2), .ch(ch2), .valid(valid2), .wrap(wrap2)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge N, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int d, input int at, input string nm,
                      input logic [3:0] o, input logic [2:0] c,
                      input logic v, input logic w);
    exp_t e;
    e.dut = d; e.at = at; e.name = nm;
    e.out = o; e.ch = c; e.valid = v; e.wrap = w;
    q.push_back(e);
  endtask

  task automatic check(input exp_t e, input int now);
    logic [3:0] ao;
    logic [2:0] ac;
    logic       av, aw;
    case (e.dut)
      0:       begin ao = {3'b0, out0}; ac = ch0; av = valid0; aw = wrap0; end
      1:       begin ao = out1;         ac = ch1; av = valid1; aw = wrap1; end
      default: begin ao = {3'b0, out2}; ac = ch2; av = valid2; aw = wrap2; end
    endcase
    if (e.at != now) begin
      tests++; fails++;
      $display("FAIL %s stale: expected at edge %0d, seen at edge %0d", e.name, e.at, now);
    end else begin
      tests += 4;
      if (ao !== e.out) begin
        fails++;
        $display("FAIL %s.out u%0d edge %0d: got %0d, want %0d", e.name, e.dut, now, ao, e.out);
      end
      if (ac !== e.ch) begin
        fails++;
        $display("FAIL %s.ch u%0d edge %0d: got %0d, want %0d", e.name, e.dut, now, ac, e.ch);
      end
      if (av !== e.valid) begin
        fails++;
        $display("FAIL %s.valid u%0d edge %0d: got %0b, want %0b", e.name, e.dut, now, av, e.valid);
      end
      if (aw !== e.wrap) begin
        fails++;
        $display("FAIL %s.wrap u%0d edge %0d: got %0b, want %0b", e.name, e.dut, now, aw, e.wrap);
      end
    end
  endtask

  // Monitor: check every expectation due at (or overdue by) this edge.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at <= cyc) begin
        check(q[i], cyc);
        $display("[TB] edge %0d u%0d %s checked", cyc, q[i].dut, q[i].name);
        q.delete(i);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Hold reset for two edges, expecting the cleared state after each.
  task automatic reset_dut(input int d);
    rst_n = 1'b0;
    push(d, cyc + 1, "reset", 4'd0, 3'd0, 1'b0, 1'b0);
    push(d, cyc + 2, "reset", 4'd0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    int t;
    int c;
    tick();

    // 1: reset and manual select with defaults.
    mode = 1'b0; sel = 3'd5;
    reset_dut(0);
    rst_n = 1'b1; t = cyc;
    push(0, t + 1, "man_first", 4'd0, 3'd0, 1'b1, 1'b0);
    push(0, t + 2, "man_sel5", 4'd1, 3'd5, 1'b1, 1'b0);
    tick(); tick();
    sel = 3'd4; t = cyc;
    push(0, t + 1, "man_sel4_lag", 4'd1, 3'd5, 1'b1, 1'b0);
    push(0, t + 2, "man_sel4", 4'd0, 3'd4, 1'b1, 1'b0);
    tick(); tick();

    // 2: 4-bit, 5-channel manual select, then an out-of-range select.
    reset_dut(1);
    rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      sel = 3'(s);
      push(1, cyc + 2, "w4_sel", 4'(s + 3), 3'(s), 1'b1, 1'b0);
      tick();
    end
    sel = 3'd6; t = cyc;
    for (int k = 1; k <= 3; k++) push(1, t + k, "w4_oob", 4'd7, 3'd4, 1'b1, 1'b0);
    tick(); tick(); tick();

    // 3: full scan, two sweeps.
    mode = 1'b0; sel = 3'd0;
    reset_dut(0);
    rst_n = 1'b1; mode = 1'b1; hold = 1'b0; t = cyc;
    for (int i = 0; i < 64; i++) begin
      c = (i / 4) % 8;
      push(0, t + 1 + i, "scan", 4'(c == 5), 3'(c), 1'b1, (i % 32) == 31);
    end
    for (int i = 0; i < 64; i++) tick();

    // 4: hold for 10 edges while on channel 3 with cnt = 1.
    mode = 1'b0;
    reset_dut(0);
    rst_n = 1'b1; mode = 1'b1; t = cyc;
    for (int k = 13; k <= 26; k++) push(0, t + k, "hold_ch3", 4'd0, 3'd3, 1'b1, 1'b0);
    push(0, t + 27, "hold_ch4", 4'd0, 3'd4, 1'b1, 1'b0);
    for (int k = 0; k < 13; k++) tick();
    hold = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    hold = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // 5: 5 channels, dwell 1: pointer wraps at 4, wrap every 5th edge.
    mode = 1'b0;
    reset_dut(2);
    rst_n = 1'b1; mode = 1'b1; t = cyc;
    for (int i = 0; i < 15; i++) begin
      c = i % 5;
      push(2, t + 1 + i, "npot", {3'b0, data2[c]}, 3'(c), 1'b1, (i % 5) == 4);
    end
    for (int i = 0; i < 15; i++) tick();

    // 6: reset while showing channel 6, then scan -> manual switch.
    mode = 1'b0; data0 = 8'hFF;
    reset_dut(0);
    rst_n = 1'b1; mode = 1'b1; t = cyc;
    push(0, t + 25, "pre_rst_ch6", 4'd1, 3'd6, 1'b1, 1'b0);
    for (int k = 0; k < 25; k++) tick();
    rst_n = 1'b0;
    push(0, cyc + 1, "midscan_rst", 4'd0, 3'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1; t = cyc;
    push(0, t + 1, "post_rst", 4'd1, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) tick();
    mode = 1'b0; sel = 3'd2; t = cyc;
    push(0, t + 1, "to_man_lag", 4'd1, 3'd1, 1'b1, 1'b0);
    push(0, t + 2, "to_man_sel2", 4'd1, 3'd2, 1'b1, 1'b0);
    push(0, t + 3, "to_man_keep", 4'd1, 3'd2, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick();

    // Anything still queued was never observed.
    while (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL %s unchecked: due at edge %0d, now edge %0d", q[0].name, q[0].at, cyc);
      void'(q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at edge %0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
